// File: rtl/axi_w_steer_pkg.sv
// Shared AXI constants for the W-channel steering block.
package axi_w_steer_pkg;

  localparam int AXI_SEL_W_DEF = 3;

  function automatic int axi_strb_w(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/axi_w_steer_if.sv
// AW-selection, master W and fanned-out slave W signals for axi_w_steer.
interface axi_w_steer_if
  import axi_w_steer_pkg::*;
#(
  parameter int NUM_SLAVES = 5,
  parameter int DATA_W     = 32,
  parameter int SEL_W      = AXI_SEL_W_DEF
);
  localparam int STRB_W = axi_strb_w(DATA_W);

  logic                                aw_sel_valid;
  logic [SEL_W-1:0]                    aw_sel;
  logic                                aw_sel_ready;

  logic [DATA_W-1:0]                   m_wdata;
  logic [STRB_W-1:0]                   m_wstrb;
  logic                                m_wlast;
  logic                                m_wvalid;
  logic                                m_wready;

  logic [NUM_SLAVES-1:0][DATA_W-1:0]   s_wdata;
  logic [NUM_SLAVES-1:0][STRB_W-1:0]   s_wstrb;
  logic [NUM_SLAVES-1:0]               s_wlast;
  logic [NUM_SLAVES-1:0]               s_wvalid;
  logic [NUM_SLAVES-1:0]               s_wready;

  modport master (
    output aw_sel_valid, aw_sel, m_wdata, m_wstrb, m_wlast, m_wvalid, s_wready,
    input  aw_sel_ready, m_wready, s_wdata, s_wstrb, s_wlast, s_wvalid
  );

  modport slave (
    input  aw_sel_valid, aw_sel, m_wdata, m_wstrb, m_wlast, m_wvalid, s_wready,
    output aw_sel_ready, m_wready, s_wdata, s_wstrb, s_wlast, s_wvalid
  );

endinterface

// File: rtl/axi_w_steer_sel_fifo.sv
// Slave-select FIFO; pointers wrap naturally because DEPTH is a power of two.
module sel_fifo #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (PTR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/axi_w_steer.sv
// Steers the single master W stream to the slave selected by the queued AW
// decode; out-of-range selects are accepted and discarded as a sink burst.
module axi_w_steer
  import axi_w_steer_pkg::*;
#(
  parameter int NUM_SLAVES = 5,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 4,
  parameter int SEL_W      = AXI_SEL_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  axi_w_steer_if.slave             bus,
  output logic                     w_drop,
  output logic [$clog2(DEPTH):0]   outstanding
);
  logic [SEL_W-1:0]      head;
  logic                  empty;
  logic                  full;
  logic                  head_ok;
  logic                  pop;
  logic                  m_wready;
  logic                  drop;
  logic [NUM_SLAVES-1:0] s_wvalid;
  logic [NUM_SLAVES-1:0] s_wlast;

  sel_fifo #(
    .WIDTH (SEL_W),
    .DEPTH (DEPTH)
  ) u_sel_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (bus.aw_sel_valid),
    .push_data (bus.aw_sel),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (outstanding)
  );

  assign head_ok = ({1'b0, head} < (SEL_W+1)'(NUM_SLAVES));
  assign pop     = bus.m_wvalid && m_wready && bus.m_wlast;

  always_comb begin
    s_wvalid = '0;
    s_wlast  = '0;
    m_wready = 1'b0;
    drop     = 1'b0;
    if (!empty) begin
      if (head_ok) begin
        for (int i = 0; i < NUM_SLAVES; i++) begin
          if (head == SEL_W'(i)) begin
            s_wvalid[i] = bus.m_wvalid;
            s_wlast[i]  = bus.m_wlast;
            m_wready    = bus.s_wready[i];
          end
        end
      end else begin
        m_wready = 1'b1;
        drop     = bus.m_wvalid;
      end
    end
  end

  assign bus.aw_sel_ready = !full;
  assign bus.m_wready     = m_wready;
  assign bus.s_wvalid     = s_wvalid;
  assign bus.s_wlast      = s_wlast;
  assign bus.s_wdata      = {NUM_SLAVES{bus.m_wdata}};
  assign bus.s_wstrb      = {NUM_SLAVES{bus.m_wstrb}};
  assign w_drop           = drop;

endmodule

// File: tb/tb_axi_w_steer.sv
// Directed vector table, queue-model random run and reset-mid-burst check.
module tb_axi_w_steer;
  import axi_w_steer_pkg::*;

  localparam int NS    = 5;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int SW    = 3;
  localparam int SB    = DW / 8;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic w_drop;
  logic [OW-1:0] outstanding;
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  axi_w_steer_if #(.NUM_SLAVES(NS), .DATA_W(DW), .SEL_W(SW)) bus ();

  axi_w_steer #(.NUM_SLAVES(NS), .DATA_W(DW), .DEPTH(DEPTH), .SEL_W(SW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .w_drop      (w_drop),
    .outstanding (outstanding)
  );

  typedef struct packed {
    logic        awv;
    logic [2:0]  sel;
    logic        wv;
    logic        wl;
    logic [4:0]  sr;
    logic        mwr;
    logic [4:0]  sv;
    logic [4:0]  sl;
    logic        drop;
    logic [2:0]  out;
    logic        awr;
  } vec_t;

  vec_t tbl [22];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic awv, input logic [2:0] sel, input logic wv,
                       input logic wl, input logic [4:0] sr);
    bus.aw_sel_valid = awv;
    bus.aw_sel       = sel;
    bus.m_wvalid     = wv;
    bus.m_wlast      = wl;
    bus.s_wready     = sr;
    bus.m_wdata      = $urandom;
    bus.m_wstrb      = SB'($urandom);
  endtask

  task automatic check_all(input string tag, input logic mwr, input logic [4:0] sv,
                           input logic [4:0] sl, input logic drop, input logic [2:0] out,
                           input logic awr);
    logic bc_ok;
    bc_ok = 1'b1;
    for (int i = 0; i < NS; i++) begin
      if (bus.s_wdata[i] !== bus.m_wdata || bus.s_wstrb[i] !== bus.m_wstrb) bc_ok = 1'b0;
    end
    chk({tag, ".m_wready"},     64'(bus.m_wready),     64'(mwr));
    chk({tag, ".s_wvalid"},     64'(bus.s_wvalid),     64'(sv));
    chk({tag, ".s_wlast"},      64'(bus.s_wlast),      64'(sl));
    chk({tag, ".w_drop"},       64'(w_drop),           64'(drop));
    chk({tag, ".outstanding"},  64'(outstanding),      64'(out));
    chk({tag, ".aw_sel_ready"}, 64'(bus.aw_sel_ready), 64'(awr));
    chk({tag, ".broadcast"},    64'(bc_ok),            64'(1'b1));
  endtask

  initial begin
    int q[$];
    logic [4:0] e_sv, e_sl;
    logic e_mwr, e_drop, awv, wv, wl;
    logic [2:0] sel;
    logic [4:0] sr;

    //            awv sel   wv  wl  sr        mwr sv        sl        drp out awr
    tbl[0]  = '{1'b1, 3'd2, 1'b1, 1'b0, 5'b11111, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1};
    tbl[1]  = '{1'b0, 3'd0, 1'b1, 1'b0, 5'b11111, 1'b1, 5'b00100, 5'b00000, 1'b0, 3'd1, 1'b1};
    tbl[2]  = '{1'b0, 3'd0, 1'b1, 1'b0, 5'b11111, 1'b1, 5'b00100, 5'b00000, 1'b0, 3'd1, 1'b1};
    tbl[3]  = '{1'b0, 3'd0, 1'b1, 1'b0, 5'b11011, 1'b0, 5'b00100, 5'b00000, 1'b0, 3'd1, 1'b1};
    tbl[4]  = '{1'b0, 3'd0, 1'b1, 1'b0, 5'b11111, 1'b1, 5'b00100, 5'b00000, 1'b0, 3'd1, 1'b1};
    tbl[5]  = '{1'b0, 3'd0, 1'b1, 1'b1, 5'b11111, 1'b1, 5'b00100, 5'b00100, 1'b0, 3'd1, 1'b1};
    tbl[6]  = '{1'b0, 3'd0, 1'b0, 1'b0, 5'b11111, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1};
    tbl[7]  = '{1'b1, 3'd0, 1'b0, 1'b0, 5'b11111, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1};
    tbl[8]  = '{1'b1, 3'd1, 1'b0, 1'b0, 5'b11111, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd1, 1'b1};
    tbl[9]  = '{1'b1, 3'd3, 1'b0, 1'b0, 5'b11111, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd2, 1'b1};
    tbl[10] = '{1'b1, 3'd6, 1'b0, 1'b0, 5'b11111, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd3, 1'b1};
    tbl[11] = '{1'b1, 3'd4, 1'b1, 1'b1, 5'b11111, 1'b1, 5'b00001, 5'b00001, 1'b0, 3'd4, 1'b0};
    tbl[12] = '{1'b0, 3'd0, 1'b1, 1'b1, 5'b11111, 1'b1, 5'b00010, 5'b00010, 1'b0, 3'd3, 1'b1};
    tbl[13] = '{1'b0, 3'd0, 1'b1, 1'b1, 5'b11111, 1'b1, 5'b01000, 5'b01000, 1'b0, 3'd2, 1'b1};
    tbl[14] = '{1'b0, 3'd0, 1'b1, 1'b0, 5'b11111, 1'b1, 5'b00000, 5'b00000, 1'b1, 3'd1, 1'b1};
    tbl[15] = '{1'b0, 3'd0, 1'b0, 1'b0, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b0, 3'd1, 1'b1};
    tbl[16] = '{1'b0, 3'd0, 1'b1, 1'b1, 5'b00000, 1'b1, 5'b00000, 5'b00000, 1'b1, 3'd1, 1'b1};
    tbl[17] = '{1'b1, 3'd4, 1'b1, 1'b1, 5'b11111, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1};
    tbl[18] = '{1'b1, 3'd0, 1'b1, 1'b1, 5'b11111, 1'b1, 5'b10000, 5'b10000, 1'b0, 3'd1, 1'b1};
    tbl[19] = '{1'b0, 3'd0, 1'b1, 1'b1, 5'b11110, 1'b0, 5'b00001, 5'b00001, 1'b0, 3'd1, 1'b1};
    tbl[20] = '{1'b0, 3'd0, 1'b1, 1'b1, 5'b11111, 1'b1, 5'b00001, 5'b00001, 1'b0, 3'd1, 1'b1};
    tbl[21] = '{1'b0, 3'd0, 1'b0, 1'b0, 5'b11111, 1'b0, 5'b00000, 5'b00000, 1'b0, 3'd0, 1'b1};

    drive(1'b0, 3'd0, 1'b1, 1'b1, 5'b11111);
    repeat (3) @(posedge clk);
    #1;
    check_all("in_reset", 1'b0, 5'b0, 5'b0, 1'b0, 3'd0, 1'b1);
    rst_n = 1'b1;

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].awv, tbl[i].sel, tbl[i].wv, tbl[i].wl, tbl[i].sr);
      @(negedge clk);
      check_all($sformatf("vec%0d", i), tbl[i].mwr, tbl[i].sv, tbl[i].sl,
                tbl[i].drop, tbl[i].out, tbl[i].awr);
      @(posedge clk);
      #1;
    end

    // Random traffic against an in-order queue of pending selections.
    for (int c = 0; c < 400; c++) begin
      awv = ($urandom_range(0, 1) == 1);
      sel = 3'($urandom_range(0, 7));
      wv  = ($urandom_range(0, 9) < 7);
      wl  = ($urandom_range(0, 9) < 4);
      sr  = 5'($urandom) | 5'($urandom);
      drive(awv, sel, wv, wl, sr);
      e_sv = '0; e_sl = '0; e_mwr = 1'b0; e_drop = 1'b0;
      if (q.size() > 0) begin
        if (q[0] < NS) begin
          e_sv[q[0]] = wv;
          e_sl[q[0]] = wl;
          e_mwr      = sr[q[0]];
        end else begin
          e_mwr  = 1'b1;
          e_drop = wv;
        end
      end
      @(negedge clk);
      check_all($sformatf("rnd%0d", c), e_mwr, e_sv, e_sl, e_drop, 3'(q.size()),
                q.size() < DEPTH);
      if (awv && q.size() < DEPTH) q.push_back(int'(sel));
      if (wv && e_mwr && wl) void'(q.pop_front());
      @(posedge clk);
      #1;
    end

    // Reset asserted in the middle of a four-beat burst with a second burst queued.
    rst_n = 1'b0;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 5'b11111);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b1, 3'd3, 1'b0, 1'b0, 5'b11111);
    @(negedge clk);
    check_all("rst_push", 1'b0, 5'b0, 5'b0, 1'b0, 3'd0, 1'b1);
    @(posedge clk); #1;
    drive(1'b1, 3'd1, 1'b1, 1'b0, 5'b11111);
    @(negedge clk);
    check_all("rst_beat1", 1'b1, 5'b01000, 5'b0, 1'b0, 3'd1, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 1'b1, 1'b0, 5'b11111);
    @(negedge clk);
    check_all("rst_beat2", 1'b1, 5'b01000, 5'b0, 1'b0, 3'd2, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 1'b1, 1'b0, 5'b11111);
    #2;
    check_all("rst_beat3", 1'b1, 5'b01000, 5'b0, 1'b0, 3'd2, 1'b1);
    rst_n = 1'b0;
    #1;
    check_all("rst_mid", 1'b0, 5'b0, 5'b0, 1'b0, 3'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(1'b0, 3'd0, 1'b1, 1'b1, 5'b11111);
    @(negedge clk);
    check_all("rst_after", 1'b0, 5'b0, 5'b0, 1'b0, 3'd0, 1'b1);
    @(posedge clk); #1;
    drive(1'b0, 3'd0, 1'b0, 1'b0, 5'b11111);
    @(negedge clk);
    check_all("rst_idle", 1'b0, 5'b0, 5'b0, 1'b0, 3'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_w_steer.md
AXI_W_STEER -- requirements
Module: axi_w_steer

Interface
REQ-001 SHALL have parameter NUM_SLAVES, default 5: number of write-data slave ports, range 2..16.
REQ-002 SHALL have parameter DATA_W, default 32: W data width, a multiple of 8; strobe width is DATA_W/8.
REQ-003 SHALL have parameter DEPTH, default 4: outstanding AW selections held, a power of two, at least 2.
REQ-004 SHALL have parameter SEL_W, default 3: slave-select width, with 2**SEL_W > NUM_SLAVES.
REQ-005 SHALL use one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- aw_sel_valid  in  1  AW accepted upstream; push aw_sel.
- aw_sel  in  SEL_W  decoded slave index for that burst.
- aw_sel_ready  out  1  selection queue can accept a push.
- m_wdata  in  DATA_W  master write data.
- m_wstrb  in  DATA_W/8  master write strobe.
- m_wlast, m_wvalid  in  1 each  master last-beat flag and valid.
- m_wready  out  1  master ready.
- s_wdata  out  NUM_SLAVES x DATA_W  per-slave write data.
- s_wstrb  out  NUM_SLAVES x DATA_W/8  per-slave write strobe.
- s_wlast, s_wvalid  out  NUM_SLAVES each  per-slave last flag and valid.
- s_wready  in  NUM_SLAVES  per-slave ready.
- w_drop  out  1  pulse: one beat discarded for an invalid select.
- outstanding  out  $clog2(DEPTH)+1  queue occupancy.

Function
REQ-006 SHALL hold the selections in a FIFO of DEPTH entries; push when aw_sel_valid && aw_sel_ready, with aw_sel_ready = !full.
REQ-007 SHALL pop the FIFO head on a beat handshake with m_wlast=1 (m_wvalid && m_wready && m_wlast).
REQ-008 SHALL NOT bypass an empty FIFO: a selection pushed in cycle N first steers W in cycle N+1.
REQ-009 SHALL, while the FIFO is empty, hold m_wready=0 and all s_wvalid=0.
REQ-010 SHALL, when the head is valid and head < NUM_SLAVES:
- s_wvalid[head]=m_wvalid and s_wlast[head]=m_wlast.
- all other s_wvalid and s_wlast bits = 0.
- m_wready = s_wready[head].
- the path is combinational, with zero added latency.
REQ-011 SHALL broadcast m_wdata and m_wstrb to every s_wdata and s_wstrb slot, whatever the selection.
REQ-012 SHALL treat a head >= NUM_SLAVES as a sink burst:
- m_wready=1 and all s_wvalid=0.
- w_drop=1 in each cycle with m_wvalid=1.
- the entry pops on the wlast beat.
REQ-013 SHALL, on a push and a pop in the same cycle, keep occupancy unchanged and store the new entry correctly, including when the FIFO is full (pop only) or holds one entry.
REQ-014 SHALL wrap its read and write pointers modulo DEPTH; outstanding SHALL equal pushes minus pops and never exceed DEPTH.
REQ-015 SHALL keep the head until its wlast beat completes; a beat stalled with s_wready=0 SHALL keep s_wvalid asserted and SHALL NOT advance the FIFO.
REQ-016 SHALL count beats only for the active head; there is no burst-length check.

Reset
REQ-017 SHALL, while rst_n=0:
- empty the FIFO and clear both pointers and outstanding.
- drive w_drop=0, m_wready=0, all s_wvalid=0 and all s_wlast=0.
- drive aw_sel_ready=1 once reset is deasserted.
REQ-018 SHALL discard queued selections on reset asserted mid-burst; no partial-burst state survives reset.

Structure
REQ-019 SHALL take the shared AXI constants (strobe-width rule, the default SEL_W) from the project AXI package; no module-local typedefs.
REQ-020 SHALL implement the FIFO as one sub-module, sel_fifo, parametrised by width SEL_W and by DEPTH, exposing full, empty and count.

Verification
REQ-021 Single burst: push sel=2, then 4 beats with the last marked wlast -> only s_wvalid[2] asserts, 4 handshakes, FIFO empty afterwards.
REQ-022 Back-pressure: sel=1 with s_wready[1] low for 3 cycles -> m_wready=0 and s_wvalid[1] stays high with stable data; the beat completes when ready rises.
REQ-023 Queue full: push sel=0,1,2,3 with no W traffic -> aw_sel_ready=0 and outstanding=4; a push and a wlast pop in the same cycle -> only the pop takes effect.
REQ-024 Invalid select: push sel=6 with NUM_SLAVES=5 and send a 2-beat burst -> m_wready=1, w_drop pulses twice, no s_wvalid asserts, the next queued burst routes normally.
REQ-025 Ordering and wrap: 10 bursts alternating sel 0/4 with simultaneous push and pop -> routed in push order, pointers wrap, outstanding correct each cycle.
REQ-026 Reset mid-burst: assert rst_n=0 after beat 2 of 4 -> all s_wvalid=0 and outstanding=0 immediately, aw_sel_ready=1 after release.
